// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into an NW x 32 round-key buffer.
// Optional AES_KEYEXP_DEC_ORDER_EN adds rk_reverse so round keys can be read in decryption order.
module aes_key_expand #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [0:KEY_BITS-1] key,
    output logic                busy,
    output logic                done,
    output logic                rk_valid,
    input  logic [3:0]          rk_addr,
`ifdef AES_KEYEXP_DEC_ORDER_EN
    input  logic                rk_reverse,
`endif
    output logic [0:127]        rk_data
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_6   = 6'(NK);
    localparam logic [5:0] LAST_6 = 6'(NW - 1);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [3:0] NR_4   = 4'(NR);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      state_r;
    logic [5:0]  idx_r;
    logic [2:0]  kmod_r;
    logic [7:0]  rcon_r;
    logic [31:0] w_r [0:NW-1];

    logic [31:0] prev_s;
    logic [31:0] sub_in_s;
    logic [31:0] sub_out_s;
    logic [31:0] temp_s;
    logic [31:0] new_word_s;
    logic        rd_ok_s;
    logic [3:0]  mapped_s;
    logic [3:0]  round_s;
    logic [5:0]  base_s;

    // Next schedule word w[i] from w[i-1] and w[i-NK]; kmod_r tracks i mod NK.
    always_comb begin
        prev_s = w_r[idx_r - 6'd1];
        if (kmod_r == 3'd0) begin
            sub_in_s = {prev_s[23:0], prev_s[31:24]};
        end else begin
            sub_in_s = prev_s;
        end
        sub_out_s = {sbox(sub_in_s[31:24]), sbox(sub_in_s[23:16]),
                     sbox(sub_in_s[15:8]),  sbox(sub_in_s[7:0])};
        if (kmod_r == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_r, 24'h000000};
        end else if (NK == 8 && kmod_r == 3'd4) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = w_r[idx_r - NK_6] ^ temp_s;
    end

    // Round-key buffer: key words on the start edge, one expanded word per EXPAND edge.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && start) begin
            for (int j = 0; j < NK; j++) begin
                w_r[j] <= key[32*j +: 32];
            end
        end else if (state_r == EXPAND) begin
            w_r[idx_r] <= new_word_s;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            idx_r    <= NK_6;
            kmod_r   <= 3'd0;
            rcon_r   <= 8'h01;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        idx_r    <= NK_6;
                        kmod_r   <= 3'd0;
                        rcon_r   <= 8'h01;
                        rk_valid <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= EXPAND;
                    end
                end
                EXPAND: begin
                    idx_r <= idx_r + 6'd1;
                    if (kmod_r == NK_M1) begin
                        kmod_r <= 3'd0;
                    end else begin
                        kmod_r <= kmod_r + 3'd1;
                    end
                    if (kmod_r == 3'd0) begin
                        rcon_r <= xtime(rcon_r);
                    end
                    if (idx_r == LAST_6) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rk_valid <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    rk_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Range check happens on the raw address, before any decryption-order mapping.
    always_comb begin
        rd_ok_s = (rk_addr <= NR_4);
`ifdef AES_KEYEXP_DEC_ORDER_EN
        if (rk_reverse) begin
            mapped_s = NR_4 - rk_addr;
        end else begin
            mapped_s = rk_addr;
        end
`else
        mapped_s = rk_addr;
`endif
        if (rd_ok_s) begin
            round_s = mapped_s;
        end else begin
            round_s = 4'd0;
        end
        base_s = {round_s, 2'b00};
    end

    // Registered round-key read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_data <= '0;
        end else if (!rd_ok_s) begin
            rk_data <= '0;
        end else begin
            rk_data <= {w_r[base_s], w_r[base_s + 6'd1], w_r[base_s + 6'd2], w_r[base_s + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one instance each of AES-128/192/256 against a GF(2^8)-derived reference schedule.
module tb_aes_key_expand;

    logic         clk;
    logic         reset;
    logic         start_v [3];
    logic         busy_v  [3];
    logic         done_v  [3];
    logic         valid_v [3];
    logic [3:0]   addr_v  [3];
    logic [0:127] data_v  [3];
    logic [255:0] kb      [3];
`ifdef AES_KEYEXP_DEC_ORDER_EN
    logic         rev;
`endif

    int compared;
    int mism;
    logic [7:0]  sbox_t [256];
    logic [31:0] ref_w  [3][60];

    aes_key_expand #(.KEY_BITS(128)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .key(kb[0][255:128]),
        .busy(busy_v[0]), .done(done_v[0]), .rk_valid(valid_v[0]), .rk_addr(addr_v[0]),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rk_reverse(rev),
`endif
        .rk_data(data_v[0]));

    aes_key_expand #(.KEY_BITS(192)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .key(kb[1][255:64]),
        .busy(busy_v[1]), .done(done_v[1]), .rk_valid(valid_v[1]), .rk_addr(addr_v[1]),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rk_reverse(rev),
`endif
        .rk_data(data_v[1]));

    aes_key_expand #(.KEY_BITS(256)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .key(kb[2]),
        .busy(busy_v[2]), .done(done_v[2]), .rk_valid(valid_v[2]), .rk_addr(addr_v[2]),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rk_reverse(rev),
`endif
        .rk_data(data_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic ref_expand(input int s, input logic [255:0] k);
        int nk = 4 + 2 * s;
        int nw = 4 * (nk + 7);
        logic [31:0] t;
        logic [7:0] rc;
        for (int i = 0; i < nk; i++) ref_w[s][i] = k[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = ref_w[s][i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[s][i] = ref_w[s][i-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_round(input int s, input int r, output logic [127:0] v);
        addr_v[s] = 4'(r);
        @(negedge clk);
        v = data_v[s];
    endtask

    task automatic check_all(input int s);
        logic [127:0] v;
        logic [127:0] e;
        int nr = 10 + 2 * s;
        for (int r = 0; r < 16; r++) begin
            read_round(s, r, v);
            e = (r > nr) ? 128'h0 : {ref_w[s][4*r], ref_w[s][4*r+1], ref_w[s][4*r+2], ref_w[s][4*r+3]};
            chk($sformatf("rk s%0d r%0d", s, r), v, e);
        end
    endtask

    // Caller is at a negedge; start is raised immediately and the task returns in the done cycle.
    task automatic run_expand(input int s, input logic [255:0] k, input int exp_n);
        int n = 0;
        kb[s] = k;
        ref_expand(s, k);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("busy_after_start", 128'(busy_v[s]), 128'h1);
        chk("valid_clr_after_start", 128'(valid_v[s]), 128'h0);
        while (done_v[s] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_latency s%0d", s), 128'(n), 128'(exp_n));
        chk("valid_at_done", 128'(valid_v[s]), 128'h1);
        chk("busy_at_done", 128'(busy_v[s]), 128'h0);
    endtask

    initial begin
        logic [127:0] v;
        logic [255:0] fips;
        logic [255:0] kr;
        int n;
        compared = 0;
        mism = 0;
        reset = 1'b0;
`ifdef AES_KEYEXP_DEC_ORDER_EN
        rev = 1'b0;
`endif
        for (int s = 0; s < 3; s++) begin
            start_v[s] = 1'b0;
            addr_v[s] = 4'd0;
            kb[s] = 256'h0;
        end
        build_sbox();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", 128'(busy_v[s]), 128'h0);
            chk("rst_done", 128'(done_v[s]), 128'h0);
            chk("rst_valid", 128'(valid_v[s]), 128'h0);
            chk("rst_data", data_v[s], 128'h0);
        end
        reset = 1'b1;
        @(negedge clk);

        fips = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_expand(0, fips, 40);
        @(negedge clk);
        chk("done_pulse_width", 128'(done_v[0]), 128'h0);
        read_round(0, 1, v);
        chk("fips128 r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_round(0, 10, v);
        chk("fips128 r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_all(0);

        run_expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 40);
        read_round(0, 10, v);
        chk("seq128 r10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_round(0, 11, v);
        chk("seq128 r11", v, 128'h0);

        run_expand(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 46);
        read_round(1, 12, v);
        chk("fips192 r12", v, 128'he98ba06f448c773c8ecc720401002202);
        check_all(1);

        run_expand(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 52);
        read_round(2, 14, v);
        chk("fips256 r14", v, 128'hfe4890d1e6188d0b046df344706c631e);
        check_all(2);

        for (int s = 0; s < 3; s++) begin
            for (int rep = 0; rep < 2; rep++) begin
                kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                run_expand(s, kr, 40 + 6 * s);
                check_all(s);
            end
        end

        // Second start during expansion with a different key must be ignored.
        kb[0] = fips;
        ref_expand(0, fips);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        repeat (9) begin
            @(negedge clk);
            n++;
        end
        kb[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start_v[0] = 1'b1;
        @(negedge clk);
        n++;
        start_v[0] = 1'b0;
        while (done_v[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_start_latency", 128'(n), 128'd40);
        read_round(0, 10, v);
        chk("busy_start r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: second start lands in the done cycle of the first.
        run_expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 40);
        run_expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 40);
        check_all(0);

        // Asynchronous reset in the middle of an expansion.
        kb[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_busy", 128'(busy_v[0]), 128'h0);
        chk("async_rst_valid", 128'(valid_v[0]), 128'h0);
        chk("async_rst_done", 128'(done_v[0]), 128'h0);
        chk("async_rst_data", data_v[0], 128'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 40);
        check_all(0);

`ifdef AES_KEYEXP_DEC_ORDER_EN
        run_expand(0, fips, 40);
        rev = 1'b1;
        read_round(0, 0, v);
        chk("rev r0", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_round(0, 10, v);
        chk("rev r10", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_round(0, 11, v);
        chk("rev r11", v, 128'h0);
        rev = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
